ntt_seq_ctrl: RTL

- Sequencer for the Kyber NTT/INTT datapath. Walks all 7 layers × 128 butterflies of a 256-coefficient polynomial.
- For each butterfly it issues a read-address pair and a zeta index to the coefficient RAM and the butterfly unit (modular add/sub, q=3329).
- It also drives the subtractor mode: NORMAL for the forward transform, DIV_2 for the inverse transform.
- It writes results back in place after a fixed pipeline delay, and drains that pipeline between layers to avoid read-after-write hazards.

---
 rtl/kyber_pkg.sv | 24 ++
 rtl/ntt_addr_gen.sv | 36 +++
 rtl/ntt_seq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Kyber shared constants, mode encodings and sequencer types.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int NTT_LAYERS = 7;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_DIV2   = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } ntt_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
  } wb_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly operand addresses and twiddle index for one
// (layer, bf) point of the forward or inverse Kyber NTT.
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic [2:0] layer,
  input  logic [6:0] bf,
  input  logic       inv,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] zeta_idx
);

  logic [2:0] s;
  logic [7:0] len;
  logic [7:0] g;
  logic [7:0] o;
  logic [7:0] base;
  logic [7:0] zf;
  logic [7:0] zi;

  always_comb begin
    s    = inv ? layer + 3'd1 : 3'd7 - layer;
    len  = 8'd1 << s;
    g    = {1'b0, bf} >> s;
    o    = {1'b0, bf} & (len - 8'd1);
    // shift of 8 at s=7 is fine: g is 0 there
    base = (g << ({1'b0, s} + 4'd1)) | o;
    zf   = (8'd1 << layer) + g;
    zi   = (8'd1 << (3'd7 - layer)) - 8'd1 - g;
    addr_a   = base;
    addr_b   = base + len;
    zeta_idx = inv ? zi[6:0] : zf[6:0];
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Kyber NTT/INTT sequencer: issues 7 x 128 butterflies,
// writes back after LAT cycles, drains between layers.
module ntt_seq_ctrl #(
  parameter int LAT   = 4,
  parameter int N_LOG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [N_LOG-1:0] rd_addr_a,
  output logic [N_LOG-1:0] rd_addr_b,
  output logic [6:0]       zeta_idx,
  output logic [1:0]       bf_mode,
  output logic             wr_en,
  output logic [N_LOG-1:0] wr_addr_a,
  output logic [N_LOG-1:0] wr_addr_b
);
  import kyber_pkg::*;

  ntt_state_t state, nxt_state;
  logic [2:0] layer, nxt_layer;
  logic [6:0] bf, nxt_bf;
  logic       inv_q, nxt_inv;
  logic [3:0] cnt;
  logic       drain_end;
  logic       issue_n;
  logic       busy_n;
  logic [7:0] ga, gb;
  logic [6:0] gz;
  wb_t        dl [LAT];

  assign drain_end = cnt == 4'(LAT - 1);
  assign issue_n   = nxt_state == ST_ISSUE;
  assign busy_n    = issue_n || nxt_state == ST_DRAIN;

  // Outputs are registered from the next-state view
  always_comb begin
    nxt_state = state;
    nxt_layer = layer;
    nxt_bf    = bf;
    nxt_inv   = inv_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_state = ST_ISSUE;
          nxt_layer = 3'd0;
          nxt_bf    = 7'd0;
          nxt_inv   = inv;
        end
      end
      ST_ISSUE: begin
        nxt_bf = bf + 7'd1;
        if (bf == 7'd127) nxt_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_end) begin
          if (layer == 3'd6) begin
            nxt_state = ST_FIN;
          end else begin
            nxt_state = ST_ISSUE;
            nxt_layer = layer + 3'd1;
          end
        end
      end
      ST_FIN: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  ntt_addr_gen u_gen (
    .layer    (nxt_layer),
    .bf       (nxt_bf),
    .inv      (nxt_inv),
    .addr_a   (ga),
    .addr_b   (gb),
    .zeta_idx (gz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      layer     <= '0;
      bf        <= '0;
      inv_q     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
      bf_mode   <= MODE_NORMAL;
    end else begin
      state     <= nxt_state;
      layer     <= nxt_layer;
      bf        <= nxt_bf;
      inv_q     <= nxt_inv;
      cnt       <= (state == ST_DRAIN) ? cnt + 4'd1 : 4'd0;
      busy      <= busy_n;
      done      <= nxt_state == ST_FIN;
      rd_en     <= issue_n;
      rd_addr_a <= issue_n ? ga : '0;
      rd_addr_b <= issue_n ? gb : '0;
      zeta_idx  <= issue_n ? gz : '0;
      bf_mode   <= (busy_n && nxt_inv) ? MODE_DIV2 : MODE_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{vld: rd_en, addr_a: rd_addr_a, addr_b: rd_addr_b};
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign wr_en     = dl[LAT-1].vld;
  assign wr_addr_a = dl[LAT-1].addr_a;
  assign wr_addr_b = dl[LAT-1].addr_b;

endmodule
